neander_io_port: RTL and testbench

Memory-mapped-style I/O responder for the NEANDER-X CPU: the device end of the datapath's OUT/IN interface. Bytes written by OUT are queued in a TX FIFO and drained to an external byte sink over a valid/ready handshake. Bytes arriving from an external source over valid/ready are queued in an RX FIFO and presented to IN port 0. IN port 1 reads a status byte.

---
 rtl/neander_io_port.sv | 98 +++++++++
 tb/tb_neander_io_port.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/neander_io_port.sv
// NEANDER-X I/O responder: OUT bytes queue in a TX FIFO toward a valid/ready sink, and
// source bytes queue in an RX FIFO read by IN port 0. Optional loopback: NEANDER_IO_LOOPBACK_EN.
module neander_io_port #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] io_out,
  input  logic       io_write,
  input  logic       io_read,
  input  logic       err_clr,
  output logic [7:0] io_in,
  output logic [7:0] io_status,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
`ifdef NEANDER_IO_LOOPBACK_EN
  input  logic       loopback,
`endif
  output logic       rx_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    r_txMem [DEPTH];
  logic [7:0]    r_rxMem [DEPTH];
  logic [PW-1:0] r_txWr, r_txRd, r_rxWr, r_rxRd;
  logic [CW-1:0] r_txCount, r_rxCount;
  logic          r_txOverflow, r_rxUnderflow;
  logic          r_active, r_loop;

  logic       w_loopIn;
  logic       w_txFull, w_txEmpty, w_rxFull, w_rxEmpty;
  logic       w_txPush, w_txPop, w_rxPush, w_rxPop;
  logic [7:0] w_rxByte;

`ifdef NEANDER_IO_LOOPBACK_EN
  assign w_loopIn = loopback;
`else
  assign w_loopIn = 1'b0;
`endif

  assign w_txFull  = (r_txCount == CW'(DEPTH));
  assign w_txEmpty = (r_txCount == '0);
  assign w_rxFull  = (r_rxCount == CW'(DEPTH));
  assign w_rxEmpty = (r_rxCount == '0);

  // Full/empty come from the count before the edge, so a write to a full TX is dropped
  // even when the sink pops in the same cycle.
  assign w_txPush = io_write & ~w_txFull;
  assign w_txPop  = ~w_txEmpty & (r_loop ? ~w_rxFull : tx_ready);
  assign w_rxPush = r_loop ? w_txPop : (rx_valid & rx_ready);
  assign w_rxByte = r_loop ? r_txMem[r_txRd] : rx_data;
  assign w_rxPop  = io_read & ~w_rxEmpty;

  // Payload storage is deliberately left unreset; counts alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_txPush) r_txMem[r_txWr] <= io_out;
    if (w_rxPush) r_rxMem[r_rxWr] <= w_rxByte;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_txWr        <= '0;
      r_txRd        <= '0;
      r_txCount     <= '0;
      r_rxWr        <= '0;
      r_rxRd        <= '0;
      r_rxCount     <= '0;
      r_txOverflow  <= 1'b0;
      r_rxUnderflow <= 1'b0;
      r_active      <= 1'b0;
      r_loop        <= 1'b0;
    end else begin
      if (w_txPush) r_txWr <= r_txWr + PW'(1);
      if (w_txPop)  r_txRd <= r_txRd + PW'(1);
      if (w_rxPush) r_rxWr <= r_rxWr + PW'(1);
      if (w_rxPop)  r_rxRd <= r_rxRd + PW'(1);
      r_txCount     <= r_txCount + CW'(w_txPush) - CW'(w_txPop);
      r_rxCount     <= r_rxCount + CW'(w_rxPush) - CW'(w_rxPop);
      r_txOverflow  <= (io_write & w_txFull) | (r_txOverflow & ~err_clr);
      r_rxUnderflow <= (io_read & w_rxEmpty) | (r_rxUnderflow & ~err_clr);
      r_active      <= 1'b1;
      r_loop        <= w_loopIn;
    end
  end

  // Outputs depend only on registered state; loopback itself is registered for that reason.
  assign io_in     = w_rxEmpty ? 8'h00 : r_rxMem[r_rxRd];
  assign tx_data   = w_txEmpty ? 8'h00 : r_txMem[r_txRd];
  assign tx_valid  = ~w_txEmpty & ~r_loop;
  assign rx_ready  = r_active & ~r_loop & ~w_rxFull;
  assign io_status = {3'b000, w_txEmpty, r_txOverflow, r_rxUnderflow, w_txFull, ~w_rxEmpty};

endmodule

// File: tb/tb_neander_io_port.sv
// Self-checking bench for neander_io_port: queue-based reference model compared every
// cycle, plus literal checks from the directed scenarios. Loopback test under NEANDER_IO_LOOPBACK_EN.
module tb_neander_io_port;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] io_out = 8'h00;
  logic       io_write = 1'b0, io_read = 1'b0, err_clr = 1'b0;
  logic       tx_ready = 1'b0, rx_valid = 1'b0, loopback = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] io_in, io_status, tx_data;
  logic       tx_valid, rx_ready;

  int testsRun = 0;
  int testsFailed = 0;
  bit checkEn = 1'b0;

  logic [7:0] txQ[$];
  logic [7:0] rxQ[$];
  logic [7:0] sinkLog[$];
  bit mOv = 0, mUf = 0, mActive = 0, mLoop = 0;

  neander_io_port #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .io_out(io_out), .io_write(io_write), .io_read(io_read),
    .err_clr(err_clr), .io_in(io_in), .io_status(io_status), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
`ifdef NEANDER_IO_LOOPBACK_EN
    .loopback(loopback),
`endif
    .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte queues updated from the rules of each edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      txQ.delete();
      rxQ.delete();
      mOv = 0; mUf = 0; mActive = 0; mLoop = 0;
    end else begin : modelStep
      int txN, rxN;
      bit txPop, rxAcc, extReady;
      logic [7:0] head;
      txN = txQ.size();
      rxN = rxQ.size();
      extReady = mActive && !mLoop && (rxN < DEPTH);
      txPop = (txN > 0) && (mLoop ? (rxN < DEPTH) : tx_ready);
      head = (txN > 0) ? txQ[0] : 8'h00;
      rxAcc = mLoop ? txPop : (rx_valid && extReady);
      mOv = (mOv && !err_clr) || (io_write && txN == DEPTH);
      mUf = (mUf && !err_clr) || (io_read && rxN == 0);
      if (txPop) void'(txQ.pop_front());
      if (io_write && txN < DEPTH) txQ.push_back(io_out);
      if (io_read && rxN > 0) void'(rxQ.pop_front());
      if (rxAcc) rxQ.push_back(mLoop ? head : rx_data);
      mActive = 1;
      mLoop = loopback;
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("io_in", io_in, (rxQ.size() > 0) ? rxQ[0] : 8'h00);
      checkOutput("tx_data", tx_data, (txQ.size() > 0) ? txQ[0] : 8'h00);
      checkOutput("tx_valid", {7'd0, tx_valid}, {7'd0, (txQ.size() > 0) && !mLoop});
      checkOutput("rx_ready", {7'd0, rx_ready}, {7'd0, mActive && !mLoop && (rxQ.size() < DEPTH)});
      checkOutput("io_status", io_status,
                  {3'b000, txQ.size() == 0, mOv, mUf, txQ.size() == DEPTH, rxQ.size() > 0});
      if (tx_valid && tx_ready) sinkLog.push_back(tx_data);
    end
  end

  task automatic applyStimulus(input logic wr, input logic [7:0] wdata, input logic rd,
                               input logic clr, input logic txr, input logic rxv,
                               input logic [7:0] rxd);
    io_write = wr; io_out = wdata; io_read = rd; err_clr = clr;
    tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 8'h00, 0, 0, 0, 0, 8'h00);
  endtask

  initial begin
    logic [7:0] expA[4];
    checkEn = 1'b1;
    idle();
    idle();
    checkOutput("rst_status", io_status, 8'h10);
    checkOutput("rst_rx_ready", {7'd0, rx_ready}, 8'h00);
    checkOutput("rst_tx_valid", {7'd0, tx_valid}, 8'h00);
    checkOutput("rst_io_in", io_in, 8'h00);
    reset = 1'b0;
    idle();
    checkOutput("idle_rx_ready", {7'd0, rx_ready}, 8'h01);
    checkOutput("idle_status", io_status, 8'h10);

    // Fill TX with the sink stalled, then overflow it
    expA = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) applyStimulus(1, expA[i], 0, 0, 0, 0, 8'h00);
    applyStimulus(1, 8'h55, 0, 0, 0, 0, 8'h00);
    checkOutput("ovf_status", io_status, 8'h0A);
    sinkLog.delete();
    for (int i = 0; i < 5; i++) applyStimulus(0, 8'h00, 0, 0, 1, 0, 8'h00);
    checkOutput("drain_count", 8'(sinkLog.size()), 8'd4);
    for (int i = 0; i < 4; i++)
      checkOutput("drain_byte", (i < sinkLog.size()) ? sinkLog[i] : 8'hxx, expA[i]);
    checkOutput("drained_status", io_status, 8'h18);
    applyStimulus(0, 8'h00, 0, 1, 0, 0, 8'h00);
    checkOutput("clr_status", io_status, 8'h10);

    // RX path, underflow and clear
    applyStimulus(0, 8'h00, 0, 0, 0, 1, 8'hA5);
    applyStimulus(0, 8'h00, 0, 0, 0, 1, 8'h5A);
    checkOutput("rx_head", io_in, 8'hA5);
    checkOutput("rx_avail", {7'd0, io_status[0]}, 8'h01);
    applyStimulus(0, 8'h00, 1, 0, 0, 0, 8'h00);
    checkOutput("rx_second", io_in, 8'h5A);
    applyStimulus(0, 8'h00, 1, 0, 0, 0, 8'h00);
    checkOutput("rx_empty_in", io_in, 8'h00);
    checkOutput("rx_empty_status", io_status, 8'h10);
    applyStimulus(0, 8'h00, 1, 0, 0, 0, 8'h00);
    checkOutput("udf_status", io_status, 8'h14);
    applyStimulus(0, 8'h00, 0, 1, 0, 0, 8'h00);
    checkOutput("udf_clr", io_status, 8'h10);

    // Read on empty RX while a byte arrives: flag set, byte kept
    applyStimulus(0, 8'h00, 1, 0, 0, 1, 8'hC3);
    checkOutput("udf_push_status", io_status, 8'h15);
    checkOutput("udf_push_in", io_in, 8'hC3);
    applyStimulus(0, 8'h00, 1, 1, 0, 0, 8'h00);
    checkOutput("udf_push_clr", io_status, 8'h10);

    // Full TX with write and sink pop in the same cycle
    for (int i = 1; i <= 4; i++) applyStimulus(1, 8'(i), 0, 0, 0, 0, 8'h00);
    applyStimulus(1, 8'h99, 0, 0, 1, 0, 8'h00);
    checkOutput("fullpop_status", io_status, 8'h08);
    checkOutput("fullpop_head", tx_data, 8'h02);
    sinkLog.delete();
    for (int i = 0; i < 4; i++) applyStimulus(0, 8'h00, 0, 0, 1, 0, 8'h00);
    checkOutput("fullpop_count", 8'(sinkLog.size()), 8'd3);
    checkOutput("fullpop_last", (sinkLog.size() == 3) ? sinkLog[2] : 8'hxx, 8'h04);
    applyStimulus(0, 8'h00, 0, 1, 0, 0, 8'h00);

    // Sustained one-byte-per-cycle traffic in both directions
    for (int i = 0; i < 8; i++)
      applyStimulus(1, 8'h30 + 8'(i), (i > 0), 0, 1, 1, 8'h60 + 8'(i));
    checkOutput("stream_in", io_in, 8'h67);
    checkOutput("stream_tx", tx_data, 8'h37);

    // Reset mid-operation with bytes in both FIFOs
    applyStimulus(1, 8'hA1, 0, 0, 0, 1, 8'hB1);
    applyStimulus(1, 8'hA2, 0, 0, 0, 1, 8'hB2);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_status", io_status, 8'h10);
    checkOutput("midrst_tx_valid", {7'd0, tx_valid}, 8'h00);
    checkOutput("midrst_io_in", io_in, 8'h00);
    checkOutput("midrst_rx_ready", {7'd0, rx_ready}, 8'h00);
    io_write = 0; rx_valid = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    idle();
    checkOutput("post_rst_rx_ready", {7'd0, rx_ready}, 8'h01);

`ifdef NEANDER_IO_LOOPBACK_EN
    loopback = 1'b1;
    idle();
    applyStimulus(1, 8'h7E, 0, 0, 0, 0, 8'h00);
    checkOutput("lb_tx_valid", {7'd0, tx_valid}, 8'h00);
    idle();
    checkOutput("lb_io_in", io_in, 8'h7E);
    checkOutput("lb_tx_valid2", {7'd0, tx_valid}, 8'h00);
    loopback = 1'b0;
    idle();
    idle();
`endif

    idle();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
